// File: rtl/float_to_int_pkg.sv
// Shared ALU definitions for the float-to-integer converter.
// Holds the converter FSM state encoding, IEEE-754 single-precision field
// constants, the 32-bit signed integer limits, and the helper that picks
// the out-of-range result for a given sign.
package float_to_int_pkg;

    typedef enum logic [2:0] {
        GET_Z   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        CONVERT = 3'd3,
        PACK    = 3'd4,
        PUT_INT = 3'd5
    } state_t;

    localparam int          EXP_BIAS   = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'd255;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;

    // Saturating mode clamps by sign; otherwise every overflow is INT_MIN.
    function automatic logic [31:0] ovf_value(input logic sat, input logic sign);
        if (sat && !sign) return INT_MAX;
        return INT_MIN;
    endfunction

endpackage

// File: rtl/float_to_int_fp_classify.sv
// IEEE-754 single-precision operand classifier.
// Purely combinational; shared with the divider's special-case logic.
// Ports:
//   z         in  32  float word
//   is_nan    out 1   exponent all ones, mantissa non-zero
//   is_inf    out 1   exponent all ones, mantissa zero
//   is_zero   out 1   exponent zero, mantissa zero
//   is_denorm out 1   exponent zero, mantissa non-zero
module float_to_int_fp_classify
    import float_to_int_pkg::*;
(
    input  logic [31:0] z,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        is_denorm
);

    logic exp_max;
    logic exp_zero;
    logic man_zero;

    assign exp_max  = (z[30:23] == FP_EXP_MAX);
    assign exp_zero = (z[30:23] == 8'd0);
    assign man_zero = (z[22:0] == 23'd0);

    assign is_nan    = exp_max && !man_zero;
    assign is_inf    = exp_max && man_zero;
    assign is_zero   = exp_zero && man_zero;
    assign is_denorm = exp_zero && !man_zero;

endmodule

// File: rtl/float_to_int.sv
// Single-precision float to 32-bit signed integer converter.
// Accepts a float through a strobe/ack handshake, truncates toward zero with
// a one-bit-per-cycle shifter, and returns the integer through an identical
// strobe/ack handshake. NaN yields NAN_VALUE; out-of-range values saturate
// by sign (SAT_OVERFLOW=1) or all map to INT_MIN (SAT_OVERFLOW=0).
// Ports:
//   clk        in  1   clock
//   rst        in  1   synchronous active-high reset
//   i_z        in  32  float operand
//   i_z_stb    in  1   operand valid
//   i_z_ack    out 1   operand accepted
//   o_int      out 32  signed integer result
//   o_int_stb  out 1   result valid
//   o_int_ack  in  1   result accepted
//
// state   | meaning
// GET_Z   | raise i_z_ack, wait for operand
// UNPACK  | split sign / unbiased exponent / left-aligned mantissa
// SPECIAL | NaN, inf, |x|<1 and overflow resolved directly
// CONVERT | shift mantissa right until exponent reaches 31
// PACK    | apply sign
// PUT_INT | present result until acknowledged
module float_to_int
    import float_to_int_pkg::*;
#(
    parameter bit          SAT_OVERFLOW = 1'b1,
    parameter logic [31:0] NAN_VALUE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_z,
    input  logic        i_z_stb,
    output logic        i_z_ack,
    output logic [31:0] o_int,
    output logic        o_int_stb,
    input  logic        o_int_ack
);

    state_t             state, state_nxt;
    logic [31:0]        z_q, z_nxt;
    logic               s_q, s_nxt;
    logic signed [9:0]  e_q, e_nxt;
    logic [31:0]        m_q, m_nxt;
    logic [31:0]        result_q, result_nxt;
    logic               ack_q, ack_nxt;
    logic               stb_q, stb_nxt;
    logic [31:0]        out_q, out_nxt;

    logic is_nan, is_inf, is_zero, is_denorm;

    float_to_int_fp_classify u_classify (
        .z         (z_q),
        .is_nan    (is_nan),
        .is_inf    (is_inf),
        .is_zero   (is_zero),
        .is_denorm (is_denorm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GET_Z;
            z_q      <= '0;
            s_q      <= 1'b0;
            e_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            ack_q    <= 1'b0;
            stb_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state    <= state_nxt;
            z_q      <= z_nxt;
            s_q      <= s_nxt;
            e_q      <= e_nxt;
            m_q      <= m_nxt;
            result_q <= result_nxt;
            ack_q    <= ack_nxt;
            stb_q    <= stb_nxt;
            out_q    <= out_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        z_nxt      = z_q;
        s_nxt      = s_q;
        e_nxt      = e_q;
        m_nxt      = m_q;
        result_nxt = result_q;
        ack_nxt    = ack_q;
        stb_nxt    = stb_q;
        out_nxt    = out_q;

        case (state)
            GET_Z: begin
                // ack is registered, so it first shows a cycle after entry
                ack_nxt = 1'b1;
                if (ack_q && i_z_stb) begin
                    z_nxt     = i_z;
                    ack_nxt   = 1'b0;
                    state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                s_nxt     = z_q[31];
                e_nxt     = $signed({2'b00, z_q[30:23]}) - 10'(EXP_BIAS);
                m_nxt     = {1'b1, z_q[22:0], 8'h00};
                state_nxt = SPECIAL;
            end
            SPECIAL: begin
                state_nxt = PUT_INT;
                if (is_nan) begin
                    result_nxt = NAN_VALUE;
                end else if (is_inf) begin
                    result_nxt = ovf_value(SAT_OVERFLOW, s_q);
                end else if (is_zero || is_denorm || e_q < 10'sd0) begin
                    result_nxt = '0;
                end else if (e_q > 10'sd30) begin
                    // -2^31 exactly is representable even when not saturating
                    if (s_q && e_q == 10'sd31 && z_q[22:0] == 23'd0) begin
                        result_nxt = INT_MIN;
                    end else begin
                        result_nxt = ovf_value(SAT_OVERFLOW, s_q);
                    end
                end else begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                // Leave on the same edge as the final shift so e=30 costs one cycle here.
                if (e_q < 10'sd31) begin
                    m_nxt = m_q >> 1;
                    e_nxt = e_q + 10'sd1;
                    if (e_q == 10'sd30) begin
                        state_nxt = PACK;
                    end
                end else begin
                    state_nxt = PACK;
                end
            end
            PACK: begin
                result_nxt = s_q ? (~m_q + 32'd1) : m_q;
                state_nxt  = PUT_INT;
            end
            PUT_INT: begin
                stb_nxt = 1'b1;
                out_nxt = result_q;
                if (stb_q && o_int_ack) begin
                    stb_nxt   = 1'b0;
                    state_nxt = GET_Z;
                end
            end
            default: begin
                state_nxt = GET_Z;
            end
        endcase
    end

    assign i_z_ack   = ack_q;
    assign o_int_stb = stb_q;
    assign o_int     = out_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed testbench for float_to_int.
// Two instances run in lockstep on the same operand stream: one with default
// parameters (saturating, NaN -> 0x80000000) and one non-saturating with a
// distinctive NaN value, so parameter-dependent results are checked together.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_z;
    logic        i_z_stb;
    logic        o_int_ack;

    logic        ack0, stb0, ack1, stb1;
    logic [31:0] out0, out1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NAN1 = 32'h1234_5678;

    always #5 clk = ~clk;

    float_to_int dut0 (
        .clk       (clk),
        .rst       (rst),
        .i_z       (i_z),
        .i_z_stb   (i_z_stb),
        .i_z_ack   (ack0),
        .o_int     (out0),
        .o_int_stb (stb0),
        .o_int_ack (o_int_ack)
    );

    float_to_int #(.SAT_OVERFLOW(1'b0), .NAN_VALUE(NAN1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .i_z       (i_z),
        .i_z_stb   (i_z_stb),
        .i_z_ack   (ack1),
        .o_int     (out1),
        .o_int_stb (stb1),
        .o_int_ack (o_int_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Send one operand, measure latency, check both results, then release.
    // hold > 0 keeps o_int_ack low for that many cycles after the strobe rises.
    task automatic run_op(input string tag, input logic [31:0] z,
                          input logic [31:0] exp0, input logic [31:0] exp1,
                          input int exp_lat, input int hold);
        int   n;
        int   lat;
        logic busy_ack;
        logic stable;
        logic [31:0] held;
        o_int_ack = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!ack0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ack_ready"}, 32'(ack0), 32'd1);
        i_z     = z;
        i_z_stb = 1'b1;
        @(posedge clk);
        #1;
        i_z_stb = 1'b0;
        i_z     = 32'hDEAD_BEEF;
        lat      = 0;
        busy_ack = 1'b0;
        while (!stb0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack0 || ack1) busy_ack = 1'b1;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_ack"}, 32'(busy_ack), 32'd0);
        check_eq({tag, "_stb1"}, 32'(stb1), 32'd1);
        check_eq({tag, "_int0"}, out0, exp0);
        check_eq({tag, "_int1"}, out1, exp1);
        if (hold > 0) begin
            held   = out0;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!stb0 || out0 !== held || ack0) stable = 1'b0;
            end
            check_eq({tag, "_hold_stable"}, 32'(stable), 32'd1);
            check_eq({tag, "_hold_value"}, out0, exp0);
            o_int_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_stb_drop0"}, 32'(stb0), 32'd0);
        check_eq({tag, "_stb_drop1"}, 32'(stb1), 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        rst       = 1'b1;
        i_z       = '0;
        i_z_stb   = 1'b0;
        o_int_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ack", 32'(ack0), 32'd0);
        check_eq("reset_stb", 32'(stb0), 32'd0);
        check_eq("reset_int", out0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //       tag       operand        dut0 (sat)     dut1 (nosat)   lat hold
        run_op("pi",      32'h40490FDB, 32'h0000_0003, 32'h0000_0003, 34, 0);
        run_op("m7p5",    32'hC0F00000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 33, 0);
        run_op("lt_one",  32'h3F7FFFFF, 32'h0000_0000, 32'h0000_0000,  3, 0);
        run_op("denorm",  32'h00000001, 32'h0000_0000, 32'h0000_0000,  3, 0);
        run_op("zero",    32'h00000000, 32'h0000_0000, 32'h0000_0000,  3, 0);
        run_op("one",     32'h3F800000, 32'h0000_0001, 32'h0000_0001, 35, 0);
        run_op("max_in",  32'h4EFFFFFF, 32'h7FFF_FF80, 32'h7FFF_FF80,  5, 0);
        run_op("min_in",  32'hCEFFFFFF, 32'h8000_0080, 32'h8000_0080,  5, 0);
        run_op("p2_31",   32'h4F000000, 32'h7FFF_FFFF, 32'h8000_0000,  3, 0);
        run_op("m2_31",   32'hCF000000, 32'h8000_0000, 32'h8000_0000,  3, 0);
        run_op("big_neg", 32'hD0000000, 32'h8000_0000, 32'h8000_0000,  3, 0);
        run_op("nan",     32'h7FC00000, 32'h8000_0000, NAN1,           3, 0);
        run_op("pinf",    32'h7F800000, 32'h7FFF_FFFF, 32'h8000_0000,  3, 0);
        run_op("ninf",    32'hFF800000, 32'h8000_0000, 32'h8000_0000,  3, 0);
        run_op("bp",      32'hC0F00000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 33, 10);

        // Reset in the middle of a conversion must discard the operand.
        o_int_ack = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ack0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_ack_ready", 32'(ack0), 32'd1);
        i_z     = 32'h3F800000;
        i_z_stb = 1'b1;
        @(posedge clk);
        #1;
        i_z_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (stb0 || stb1) seen = 1'b1;
        end
        check_eq("rst_no_stb", 32'(seen), 32'd0);
        check_eq("rst_idle_ack", 32'(ack0), 32'd1);

        run_op("after_rst", 32'h42280000, 32'h0000_002A, 32'h0000_002A, 30, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
# float_to_int

Downstream consumer of the single-precision floating-point divider in the ALU: it takes each IEEE-754 result word through the same strobe/ack handshake the divider drives on its output and converts it to a 32-bit two's-complement integer. Conversion truncates toward zero, with defined saturation and NaN results. A multi-cycle shift FSM does the work, so the integer appears after a data-dependent latency. The integer leaves through an identical strobe/ack handshake.

## Interface
- SAT_OVERFLOW, default 1: 1 = out-of-range saturates by sign (0x7FFFFFFF / 0x80000000); 0 = every out-of-range result is 0x80000000
- NAN_VALUE, default 32'h80000000: integer produced for any NaN input
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- i_z  input  32  float operand; connects to divider o_z
- i_z_stb  input  1  operand valid; connects to divider o_z_stb
- i_z_ack  output  1  operand accepted; connects to divider o_z_ack
- o_int  output  32  signed integer result
- o_int_stb  output  1  result valid
- o_int_ack  input  1  result accepted by consumer

## Operation
- FSM states:
  - get_z: raise i_z_ack one cycle after entry. On an edge with i_z_ack && i_z_stb, latch i_z, drop i_z_ack, go to unpack.
  - unpack: s = z[31]; e = z[30:23] − 127, held in 10-bit signed; m = {1, z[22:0], 8'b0}, 32 bits. Go to special.
  - special, first match wins:
    - z[30:23] == 255 && mantissa ≠ 0 → NAN_VALUE
    - z[30:23] == 255 (±inf) → overflow value for sign s
    - e < 0; covers ±0, denormals and |x| < 1 → 0
    - e > 30 → overflow value. Exception: s=1, e=31, mantissa=0 is exactly −2^31 → 0x80000000
    - Any of the above jumps to put_int; otherwise go to convert.
  - convert: while e < 31, m <= m >> 1 and e <= e + 1, one bit per cycle. When e == 31, go to pack.
  - pack: result = s ? −m : m, taken mod 2^32. Go to put_int.
  - put_int: o_int_stb <= 1 and o_int <= result. On an edge with o_int_stb && o_int_ack, drop o_int_stb and return to get_z.
- Overflow value: SAT_OVERFLOW=1 gives s ? 0x80000000 : 0x7FFFFFFF. SAT_OVERFLOW=0 gives 0x80000000.
- Discarded fraction bits have no effect on the result (truncation; no rounding, no inexact flag).

## Timing
- Reset values: i_z_ack = 0, o_int_stb = 0, o_int = 0, state = get_z.
- rst takes priority over every state. Asserting it mid-conversion or mid-handshake discards the operand and pending result with no output strobe.
- i_z_ack first rises on the 2nd edge after leaving reset or after returning to get_z.
- Latency, counted in edges from the accept edge to the edge that first asserts o_int_stb:
  - special-case path: 3 (unpack, special, put_int)
  - normal path: 4 + (31 − e); e=0 gives 35, e=30 gives 5
- o_int is stable for as long as o_int_stb is high.
- o_int_ack held high continuously: stb is high for exactly 1 cycle per result.
- Back-to-back operands are never accepted while busy; i_z_ack stays low from the accept edge until the block is back in get_z.

## Structure
- Shared ALU package/include holds:
  - state encodings: get_z, unpack, special, convert, pack, put_int; 3-bit
  - EXP_BIAS = 127
  - FP_EXP_MAX = 255
  - INT_MIN = 32'h80000000
  - INT_MAX = 32'h7FFFFFFF
- A small classifier sub-module, fp_classify (flags: is_nan, is_inf, is_zero, is_denorm), is natural. It can be reused by the divider's special-case logic.

## Test plan
- 0x40490FDB (3.14159) → o_int = 0x00000003. Measure latency = 4 + 30 = 34 edges.
- 0xC0F00000 (−7.5) → 0xFFFFFFF9 (truncation toward zero, −7). 0x3F7FFFFF and 0x00000001 → 0x00000000.
- 0x4F000000 (2^31) → 0x7FFFFFFF with SAT_OVERFLOW=1, 0x80000000 with SAT_OVERFLOW=0. 0xCF000000 → 0x80000000 in both.
- 0x7FC00000 (NaN) → NAN_VALUE. 0xFF800000 (−inf) → 0x80000000. Both take 3-edge latency.
- Backpressure: hold o_int_ack low 10 cycles → o_int_stb and o_int hold constant, i_z_ack stays 0; on ack, stb drops the next edge.
- Assert rst during convert for 0x3F800000 → no o_int_stb ever for that operand. Next operand 0x42280000 → 0x0000002A (42).
